// File: rtl/sseg_scan4.sv
// Four-digit multiplexed seven-segment driver with guard blanking, leading-zero
// suppression and frame-synchronous double-buffered display registers.
module sseg_scan4 #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic        lz_en,
  input  logic        load,
  output logic [7:0]  sseg,
  output logic [3:0]  en_dig,
  output logic        frame_start
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST_C  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_C = PW'(GUARD);

  // Active-low segment pattern for one hex nibble, bits 6..0 = g..a.
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [PW-1:0] presc_r;
  logic [1:0]    idx_r;
  logic [15:0]   sh_val_r, pd_val_r;
  logic [3:0]    sh_dp_r, pd_dp_r;
  logic [3:0]    sh_blank_r, pd_blank_r;
  logic          pend_r;

  logic          slot_wrap_s;
  logic          frame_wrap_s;
  logic [3:0]    digit_s;
  logic [3:0]    zero_s;
  logic          supp_s;
  logic [7:0]    sseg_s;
  logic [3:0]    en_dig_s;

  assign slot_wrap_s  = (presc_r == LAST_C);
  assign frame_wrap_s = slot_wrap_s && (idx_r == 2'd3);
  assign digit_s      = sh_val_r[{idx_r, 2'b00} +: 4];

  // zero_s[k]: digit k and every digit above it are zero.
  assign zero_s[3] = (sh_val_r[15:12] == 4'h0);
  assign zero_s[2] = zero_s[3] && (sh_val_r[11:8] == 4'h0);
  assign zero_s[1] = zero_s[2] && (sh_val_r[7:4] == 4'h0);
  assign zero_s[0] = 1'b0;
  assign supp_s    = lz_en && zero_s[idx_r] && !sh_dp_r[idx_r];

  // Next-cycle segment and anode pattern for the current slot position.
  always_comb begin
    sseg_s   = 8'hFF;
    en_dig_s = 4'hF;
    if (presc_r < GUARD_C) begin
      sseg_s   = 8'hFF;
      en_dig_s = 4'hF;
    end else begin
      en_dig_s = ~(4'b0001 << idx_r);
      if (sh_blank_r[idx_r] || supp_s) begin
        sseg_s = 8'hFF;
      end else begin
        sseg_s = {~sh_dp_r[idx_r], hex_seg(digit_s)};
      end
    end
  end

  // Prescaler, digit index and registered display outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_r     <= '0;
      idx_r       <= 2'd0;
      sseg        <= 8'hFF;
      en_dig      <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      presc_r     <= slot_wrap_s ? '0 : presc_r + PW'(1);
      idx_r       <= slot_wrap_s ? idx_r + 2'd1 : idx_r;
      sseg        <= sseg_s;
      en_dig      <= en_dig_s;
      frame_start <= (presc_r == '0) && (idx_r == 2'd0);
    end
  end

  // Pending/shadow double buffer; shadow only changes at the 3->0 wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_val_r   <= 16'h0000;
      sh_dp_r    <= 4'h0;
      sh_blank_r <= 4'hF;
      pd_val_r   <= 16'h0000;
      pd_dp_r    <= 4'h0;
      pd_blank_r <= 4'h0;
      pend_r     <= 1'b0;
    end else if (load && frame_wrap_s) begin
      sh_val_r   <= value;
      sh_dp_r    <= dp;
      sh_blank_r <= blank;
      pend_r     <= 1'b0;
    end else if (load) begin
      pd_val_r   <= value;
      pd_dp_r    <= dp;
      pd_blank_r <= blank;
      pend_r     <= 1'b1;
    end else if (frame_wrap_s && pend_r) begin
      sh_val_r   <= pd_val_r;
      sh_dp_r    <= pd_dp_r;
      sh_blank_r <= pd_blank_r;
      pend_r     <= 1'b0;
    end else begin
      pend_r     <= pend_r;
    end
  end

endmodule

// File: tb/tb_sseg_scan4.sv
// Self-checking bench for sseg_scan4: directed scenarios plus random traffic,
// compared every cycle against a cycle-count based reference model.
module tb_sseg_scan4;

  localparam int RD = 4;
  localparam int GD = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  sseg;
  logic [3:0]  en_dig;
  logic        frame_start;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: cycles since reset release and the display buffers.
  int          cyc = 0;
  logic [15:0] m_sh_val = 16'h0000, m_pd_val = 16'h0000;
  logic [3:0]  m_sh_dp = 4'h0, m_pd_dp = 4'h0;
  logic [3:0]  m_sh_blank = 4'hF, m_pd_blank = 4'h0;
  logic        m_pflag = 1'b0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  sseg_scan4 #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .blank(blank),
    .lz_en(lz_en), .load(load), .sseg(sseg), .en_dig(en_dig),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    int p, i, d;
    logic [7:0] es;
    logic [3:0] ee;
    logic       ef;
    logic       wrap3;
    @(posedge clk);
    if (!reset) begin
      cyc = 0;
      m_sh_val = 16'h0000; m_sh_dp = 4'h0; m_sh_blank = 4'hF;
      m_pd_val = 16'h0000; m_pd_dp = 4'h0; m_pd_blank = 4'h0;
      m_pflag = 1'b0;
      es = 8'hFF; ee = 4'hF; ef = 1'b0;
    end else begin
      p  = cyc % RD;
      i  = (cyc / RD) % 4;
      ef = ((cyc % (4 * RD)) == 0);
      es = 8'hFF;
      ee = 4'hF;
      if (p >= GD) begin
        ee = 4'hF & ~(4'h1 << i);
        d  = int'((m_sh_val >> (4 * i)) & 16'h000F);
        if (m_sh_blank[i] ||
            (lz_en && i != 0 && (m_sh_val >> (4 * i)) == 16'h0000 && !m_sh_dp[i]))
          es = 8'hFF;
        else
          es = {~m_sh_dp[i], hex_tab[d][6:0]};
      end
      wrap3 = ((cyc % (4 * RD)) == (4 * RD - 1));
      if (load && wrap3) begin
        m_sh_val = value; m_sh_dp = dp; m_sh_blank = blank; m_pflag = 1'b0;
      end else if (load) begin
        m_pd_val = value; m_pd_dp = dp; m_pd_blank = blank; m_pflag = 1'b1;
      end else if (wrap3 && m_pflag) begin
        m_sh_val = m_pd_val; m_sh_dp = m_pd_dp; m_sh_blank = m_pd_blank; m_pflag = 1'b0;
      end
      cyc++;
    end
    #1;
    compared++;
    assert (sseg === es) else begin
      mismatched++;
      $error("FAIL sseg cyc=%0d observed=%h expected=%h", cyc, sseg, es);
    end
    compared++;
    assert (en_dig === ee) else begin
      mismatched++;
      $error("FAIL en_dig cyc=%0d observed=%h expected=%h", cyc, en_dig, ee);
    end
    compared++;
    assert (frame_start === ef) else begin
      mismatched++;
      $error("FAIL frame_start cyc=%0d observed=%b expected=%b", cyc, frame_start, ef);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance until the next edge sees frame phase ph (0..15).
  task automatic wait_phase(input int ph);
    for (int k = 0; k < 4 * RD && (cyc % (4 * RD)) != ph; k++) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int tmp;
    // Reset state, then release.
    run(3);
    reset = 1'b1;
    run(5);

    // 1234 appears after the next frame wrap.
    do_load(16'h1234, 4'h0, 4'h0);
    run(40);

    // Leading-zero suppression, live toggle of lz_en.
    lz_en = 1'b1;
    do_load(16'h00A0, 4'h0, 4'h0);
    run(36);
    lz_en = 1'b0;
    run(20);

    // Two loads in one frame: the last wins, nothing changes mid-frame.
    wait_phase(5);
    do_load(16'hBEEF, 4'h0, 4'h0);
    wait_phase(9);
    do_load(16'hCAFE, 4'h3, 4'h0);
    run(24);

    // Pending load then a load coincident with the wrap.
    wait_phase(6);
    do_load(16'h1111, 4'h0, 4'h0);
    wait_phase(15);
    do_load(16'h2222, 4'h0, 4'h0);
    run(36);

    // Decimal point and per-digit blanking.
    do_load(16'h8888, 4'b0100, 4'h0);
    run(36);
    do_load(16'h8888, 4'h0, 4'b0001);
    run(36);

    // Reset mid-slot of digit 2 discards a pending load.
    wait_phase(3);
    do_load(16'h5555, 4'h0, 4'h0);
    wait_phase(9);
    reset = 1'b0;
    step();
    reset = 1'b1;
    run(40);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      tmp   = int'($urandom_range(0, 65535));
      value = 16'(tmp >> (4 * $urandom_range(0, 4)));
      dp    = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) lz_en = ~lz_en;
      reset = ($urandom_range(0, 199) != 0);
      step();
    end
    load = 1'b0;
    reset = 1'b1;
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sseg_scan4.md
SSEG_SCAN4 -- requirements
Module: sseg_scan4

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; SHALL be >= 2.
REQ-002 Parameter GUARD, default 16: blanking cycles at the start of each digit slot; SHALL satisfy 0 <= GUARD < REFRESH_DIV.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 value  input  16  four hex digits; digit k = value[4k+3:4k], digit 0 is rightmost.
REQ-006 dp  input  4  decimal point per digit, active-high.
REQ-007 blank  input  4  force digit k dark, active-high.
REQ-008 lz_en  input  1  leading-zero suppression enable, sampled live.
REQ-009 load  input  1  single-cycle strobe; captures value, dp and blank.
REQ-010 sseg  output  8  segments, active-low; bit0=a … bit6=g, bit7=dp.
REQ-011 en_dig  output  4  digit anode enables, active-low, one-hot-low.
REQ-012 frame_start  output  1  one-cycle pulse when digit 0's slot begins.

Function
REQ-013 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at the wrap the digit index SHALL advance 0->1->2->3->0.
REQ-014 While prescaler < GUARD, en_dig SHALL be 4'b1111 and sseg 8'hFF; otherwise en_dig SHALL drive bit[index] low only.
REQ-015 sseg and en_dig SHALL be registered, reflecting the prescaler/index values of the previous cycle (1-cycle latency).
REQ-016 Hex map (bits 6..0, dp bit7=1): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
REQ-017 sseg[7] SHALL be the inverse of the displayed dp bit for the active digit.
REQ-018 A blanked digit SHALL output sseg 8'hFF with en_dig still asserted for its slot.
REQ-019 With lz_en=1, digit k (k=3..1) SHALL be blanked when it and all higher digits are 0 and its dp bit is 0; digit 0 SHALL never be zero-suppressed.
REQ-020 load SHALL capture value/dp/blank into a pending register and set a pending flag.
REQ-021 Displayed (shadow) registers SHALL update from pending only at the index wrap 3->0, then the flag SHALL clear; there is no mid-frame tearing.
REQ-022 If load coincides with the 3->0 wrap, the new inputs SHALL go directly to shadow and the flag SHALL end cleared.
REQ-023 Multiple loads within a frame: the last one wins.
REQ-024 frame_start SHALL be high for exactly the one cycle in which en_dig would first reflect index 0 (aligned with the registered outputs).

Reset
REQ-025 While reset=0 at a clock edge: prescaler=0, index=0, shadow and pending = 0, pending flag=0, blank shadow=4'b1111, en_dig=4'b1111, sseg=8'hFF, frame_start=0.
REQ-026 After reset is released, the first slot SHALL be digit 0 starting with GUARD blank cycles; a load pending at reset SHALL be discarded.
REQ-027 Reset asserted mid-slot SHALL take effect at the next edge regardless of prescaler state.

Verification (REFRESH_DIV=4, GUARD=1)
REQ-028 Reset, then load value=16'h1234, dp=0, blank=0 -> after the next 3->0 wrap, the slots show en_dig E/D/B/7 with sseg 99/B0/A4/F9 (digits 0..3), each preceded by 1 cycle of en_dig=F.
REQ-029 Load 16'h00A0 with lz_en=1 -> digits 3 and 2 give sseg FF, digit 1 gives 88, digit 0 gives C0; with lz_en=0 digits 3 and 2 give C0.
REQ-030 Load at index 1, then load again at index 2 -> display unchanged until the wrap, then shows the second value only.
REQ-031 Load coincident with the 3->0 wrap -> the new value appears in digit 0's slot of that frame; the pending flag stays 0.
REQ-032 dp=4'b0100, value=16'h8888 -> digit 2 sseg=00, others 80; blank=4'b0001 -> digit 0 sseg FF with en_dig=E.
REQ-033 Assert reset mid-slot of digit 2 -> next cycle en_dig=F, sseg=FF; after release frame_start pulses once every 16 cycles, first digit 0 slot at cycle 2.
